formula_pipe_credit_fifo: RTL and testbench

Ready/valid front-end and result buffer for a fixed-latency, valid-only arithmetic pipeline such as `formula_2_pipe`. It accepts arguments from an upstream ready/valid source and issues them to the pipeline as single-cycle `arg_vld` pulses. It captures every `res_vld`/`res` into an output FIFO and presents results downstream with ready/valid. A credit counter guarantees the FIFO never overflows, so downstream backpressure is safe even though the pipeline itself cannot stall.

---
 rtl/formula_pipe_credit_fifo.sv | 133 +++++++++++++
 tb/tb_formula_pipe_credit_fifo.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/formula_pipe_credit_fifo.sv
// Ready/valid front-end and in-order result buffer for a fixed-latency,
// non-stallable arithmetic pipeline. Each accepted argument set takes one
// credit, and the credit is returned when its result is popped downstream.
// The pipeline has no stall input, so this credit scheme is what makes
// downstream backpressure safe: with at most DEPTH results accepted but not
// yet popped, the result FIFO cannot overflow in legal operation.
module formula_pipe_credit_fifo #(
   parameter int W       = 32,
   parameter int LATENCY = 26,
   parameter int DEPTH   = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_a,
   input  logic [W-1:0] in_b,
   input  logic [W-1:0] in_c,
   output logic         pipe_arg_vld,
   output logic [W-1:0] pipe_a,
   output logic [W-1:0] pipe_b,
   output logic [W-1:0] pipe_c,
   input  logic         pipe_res_vld,
   input  logic [W-1:0] pipe_res,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_res,
   output logic         err
);

   localparam int UW = $clog2(DEPTH + 1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [UW-1:0] DEPTH_U  = UW'(DEPTH);
   localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

   // Reject configurations the FIFO and credit logic cannot support.
   if (DEPTH < 2 || LATENCY < 1) begin : g_bad_param
      $error("formula_pipe_credit_fifo: DEPTH must be >= 2 and LATENCY >= 1");
   end

   logic [UW-1:0] used_q, used_d;
   logic [UW-1:0] count_q, count_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic          err_q, err_d;
   logic [W-1:0]  mem_q [DEPTH];

   logic          in_fire;
   logic          out_fire;
   logic          full;
   logic          wr_en;
   logic [UW-1:0] in_flight;
   logic          unexpected;
   logic          overflow;

   // Pointers wrap explicitly so DEPTH does not have to be a power of two.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      if (p == LAST_PTR) begin
         return '0;
      end
      return p + PW'(1);
   endfunction

   // Handshakes and pass-through; in_ready depends only on rst and registered state.
   always_comb begin
      in_ready     = !rst && (used_q < DEPTH_U);
      in_fire      = in_valid && in_ready;
      out_valid    = (count_q != '0);
      out_fire     = out_valid && out_ready;
      pipe_arg_vld = in_fire;
      pipe_a       = in_a;
      pipe_b       = in_b;
      pipe_c       = in_c;
      out_res      = mem_q[rd_ptr_q];
      err          = err_q;
   end

   // Credit counter: one credit per accepted argument set, returned on pop.
   always_comb begin
      used_d = used_q;
      case ({in_fire, out_fire})
         2'b10:   used_d = used_q + UW'(1);
         2'b01:   if (used_q != '0) used_d = used_q - UW'(1);
         default: used_d = used_q;
      endcase
   end

   // FIFO occupancy, pointers and protocol error detection.
   always_comb begin
      full       = (count_q == DEPTH_U);
      wr_en      = pipe_res_vld && !full;
      // A stray result can leave count above used; clamp so the check stays meaningful.
      in_flight  = (used_q > count_q) ? (used_q - count_q) : '0;
      unexpected = pipe_res_vld && (in_flight == '0);
      overflow   = pipe_res_vld && full;
      err_d      = err_q || unexpected || overflow;

      count_d = count_q;
      case ({wr_en, out_fire})
         2'b10:   count_d = count_q + UW'(1);
         2'b01:   count_d = count_q - UW'(1);
         default: count_d = count_q;
      endcase

      wr_ptr_d = wr_en    ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d = out_fire ? ptr_inc(rd_ptr_q) : rd_ptr_q;
   end

   // Control state registers; reset discards all credits and queued results.
   always_ff @(posedge clk) begin
      if (rst) begin
         used_q   <= '0;
         count_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         err_q    <= 1'b0;
      end else begin
         used_q   <= used_d;
         count_q  <= count_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         err_q    <= err_d;
      end
   end

   // Result storage; contents are don't-care until count marks them valid.
   always_ff @(posedge clk) begin
      if (wr_en && !rst) begin
         mem_q[wr_ptr_q] <= pipe_res;
      end
   end

endmodule

// File: tb/tb_formula_pipe_credit_fifo.sv
// Bench for formula_pipe_credit_fifo with a behavioural fixed-latency
// pipeline computing a*b+c, and a scoreboard of expected results.
module tb_formula_pipe_credit_fifo;

   localparam int W     = 32;
   localparam int LAT   = 26;
   localparam int DEPTH = 28;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] in_a = '0, in_b = '0, in_c = '0;
   logic         pipe_arg_vld;
   logic [W-1:0] pipe_a, pipe_b, pipe_c;
   logic         pipe_res_vld;
   logic [W-1:0] pipe_res;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] out_res;
   logic         err;
   logic         stub_vld = 1'b0;

   always #5 clk = ~clk;

   formula_pipe_credit_fifo #(.W(W), .LATENCY(LAT), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_c(in_c),
      .pipe_arg_vld(pipe_arg_vld),
      .pipe_a(pipe_a), .pipe_b(pipe_b), .pipe_c(pipe_c),
      .pipe_res_vld(pipe_res_vld), .pipe_res(pipe_res),
      .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res),
      .err(err)
   );

   function automatic logic [W-1:0] f(input logic [W-1:0] a, input logic [W-1:0] b,
                                      input logic [W-1:0] c);
      return a * b + c;
   endfunction

   // Stand-in pipeline: valid-only shift register, reset by the same rst.
   logic [LAT-1:0] pv = '0;
   logic [W-1:0]   pr [LAT];
   always @(posedge clk) begin
      if (rst) pv <= '0;
      else     pv <= {pv[LAT-2:0], pipe_arg_vld};
      pr[0] <= f(pipe_a, pipe_b, pipe_c);
      for (int i = 1; i < LAT; i++) pr[i] <= pr[i-1];
   end
   assign pipe_res_vld = pv[LAT-1] | stub_vld;
   assign pipe_res     = pr[LAT-1];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_pass = 0;
   int n_total = 0;
   logic [W-1:0] exp_q[$];
   int outstanding = 0;
   int first_ov = -1;

   task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
      n_total++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, req, $time);
   endtask

   // Monitor: mid-cycle sampling of handshakes, credit model and pops.
   initial begin
      logic         prev_hold;
      logic [W-1:0] prev_res;
      logic [W-1:0] e;
      prev_hold = 1'b0;
      prev_res  = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            outstanding = 0;
            prev_hold   = 1'b0;
         end else begin
            chk("in_ready_credit", in_ready, (outstanding < DEPTH));
            if (prev_hold) begin
               chk("hold_valid", out_valid, 1);
               chk("hold_data", out_res, prev_res);
            end
            if (out_valid && first_ov < 0) first_ov = cyc;
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) chk("stale_pop", 1, 0);
               else begin
                  e = exp_q.pop_front();
                  chk("pop_data", out_res, e);
               end
            end
            if (in_valid && in_ready) outstanding++;
            if (out_valid && out_ready) outstanding--;
            prev_hold = out_valid && !out_ready;
            prev_res  = out_res;
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c,
                       input logic [W-1:0] e, output int stalls, output int acc_cyc);
      int n;
      n = 0;
      in_a = a; in_b = b; in_c = c;
      in_valid = 1'b1;
      while (!in_ready && n < 200) begin
         step();
         n++;
      end
      stalls = n;
      acc_cyc = cyc;
      if (!in_ready) begin
         chk("send_timeout", 0, 1);
         in_valid = 1'b0;
         return;
      end
      exp_q.push_back(e);
      step();
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      while (exp_q.size() != 0 && n < 2000) begin
         step();
         n++;
      end
      chk("drain_done", (exp_q.size() == 0), 1);
      repeat (2) step();
      chk("drain_idle", out_valid, 0);
   endtask

   typedef struct {
      logic [W-1:0] a, b, c, e;
   } vec_t;
   vec_t vecs[8];

   initial begin
      int st, ac, t0, stalls, accepts, pops, stale;
      logic [W-1:0] a, b, c, fb;

      vecs[0] = '{32'd2,          32'd3,          32'd4,          32'd10};
      vecs[1] = '{32'd0,          32'd0,          32'd0,          32'd0};
      vecs[2] = '{32'hFFFF_FFFF,  32'd2,          32'd1,          32'hFFFF_FFFF};
      vecs[3] = '{32'h0001_0000,  32'h0001_0000,  32'd5,          32'd5};
      vecs[4] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd0,          32'd1};
      vecs[5] = '{32'd7,          32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFFF};
      vecs[6] = '{32'h1234_5678,  32'd1,          32'd0,          32'h1234_5678};
      vecs[7] = '{32'd3,          32'd5,          32'hFFFF_FFF1,  32'd0};

      // Reset behaviour, with in_valid asserted to prove nothing is accepted.
      rst = 1'b1;
      in_valid = 1'b1;
      repeat (3) step();
      chk("rst_in_ready", in_ready, 0);
      chk("rst_arg_vld", pipe_arg_vld, 0);
      in_valid = 1'b0;
      rst = 1'b0;
      #1;
      chk("post_rst_in_ready", in_ready, 1);
      chk("post_rst_out_valid", out_valid, 0);
      chk("post_rst_err", err, 0);

      // Table vectors with hand-computed results.
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) send(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].e, st, ac);
      drain();

      // Streaming at DEPTH = LATENCY+2 with no backpressure.
      first_ov = -1;
      stalls = 0;
      t0 = -1;
      out_ready = 1'b1;
      for (int i = 0; i < 200; i++) begin
         a = $urandom; b = $urandom; c = $urandom;
         send(a, b, c, f(a, b, c), st, ac);
         stalls += st;
         if (i == 0) t0 = ac;
      end
      chk("stream_stalls", stalls, 0);
      drain();
      chk("stream_first_latency", first_ov - t0, LAT + 1);
      chk("stream_err", err, 0);

      // Full backpressure: credits run out at exactly DEPTH accepts.
      out_ready = 1'b0;
      accepts = 0;
      in_valid = 1'b1;
      repeat (DEPTH + LAT + 8) begin
         in_a = $urandom; in_b = $urandom; in_c = $urandom;
         if (in_ready) begin
            exp_q.push_back(f(in_a, in_b, in_c));
            accepts++;
         end
         step();
      end
      in_valid = 1'b0;
      chk("bp_accepts", accepts, DEPTH);
      chk("bp_in_ready_low", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_head", out_res, exp_q[0]);
      out_ready = 1'b1;
      step();
      chk("bp_ready_after_pop", in_ready, 1);
      pops = 1;
      repeat (DEPTH - 1) begin
         if (out_valid) pops++;
         step();
      end
      chk("bp_pops", pops, DEPTH);
      chk("bp_empty", out_valid, 0);
      drain();

      // Accept and pop in the same cycle with used = DEPTH-1.
      out_ready = 1'b0;
      for (int i = 0; i < DEPTH - 1; i++) begin
         a = $urandom; b = $urandom; c = $urandom;
         send(a, b, c, f(a, b, c), st, ac);
      end
      repeat (LAT + 2) step();
      chk("sim_ready_before", in_ready, 1);
      in_a = $urandom; in_b = $urandom; in_c = $urandom;
      in_valid = 1'b1;
      out_ready = 1'b1;
      exp_q.push_back(f(in_a, in_b, in_c));
      step();
      in_valid = 1'b0;
      out_ready = 1'b0;
      chk("sim_ready_after", in_ready, 1);
      drain();

      // FIFO write and read in the same cycle with count = 1.
      out_ready = 1'b0;
      a = 32'd11; b = 32'd13; c = 32'd17;
      send(a, b, c, f(a, b, c), st, ac);
      repeat (LAT + 2) step();
      a = 32'h0BAD_F00D; b = 32'd3; c = 32'd9;
      fb = f(a, b, c);
      send(a, b, c, fb, st, ac);
      repeat (LAT - 1) step();
      chk("wr_rd_write_cycle", pipe_res_vld, 1);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("wr_rd_valid", out_valid, 1);
      chk("wr_rd_head", out_res, fb);
      step();
      chk("wr_rd_still_one", out_valid, 1);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("wr_rd_empty", out_valid, 0);

      // Unexpected result with nothing in flight sets a sticky err.
      chk("err_pre", err, 0);
      stub_vld = 1'b1;
      step();
      stub_vld = 1'b0;
      chk("err_set", err, 1);
      repeat (5) step();
      chk("err_hold", err, 1);
      rst = 1'b1;
      exp_q.delete();
      step();
      rst = 1'b0;
      #1;
      chk("err_cleared", err, 0);
      chk("err_rst_out_valid", out_valid, 0);

      // Reset with 5 results queued and 10 in flight.
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         a = $urandom; b = $urandom; c = $urandom;
         send(a, b, c, f(a, b, c), st, ac);
      end
      repeat (LAT) step();
      for (int i = 0; i < 10; i++) begin
         a = $urandom; b = $urandom; c = $urandom;
         send(a, b, c, f(a, b, c), st, ac);
      end
      repeat (2) step();
      chk("mrst_queued", out_valid, 1);
      rst = 1'b1;
      exp_q.delete();
      step();
      rst = 1'b0;
      #1;
      chk("mrst_out_valid", out_valid, 0);
      chk("mrst_in_ready", in_ready, 1);
      out_ready = 1'b1;
      stale = 0;
      repeat (LAT + 10) begin
         if (out_valid) stale++;
         step();
      end
      chk("mrst_no_stale", stale, 0);
      for (int i = 0; i < 8; i++) send(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].e, st, ac);
      drain();

      // Random traffic at 50% valid / 50% ready.
      for (int i = 0; i < 10000; i++) begin
         in_valid  = 1'($urandom_range(0, 1));
         out_ready = 1'($urandom_range(0, 1));
         in_a = $urandom; in_b = $urandom; in_c = $urandom;
         if (in_valid && in_ready) exp_q.push_back(f(in_a, in_b, in_c));
         step();
      end
      in_valid = 1'b0;
      drain();
      chk("rand_err", err, 0);
      chk("rand_empty", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
